// File: rtl/kbd_ctrl.sv
// PS/2 keyboard drain controller: pulls scan codes out of a PS/2 receiver with a
// three-state handshake and buffers them in a show-ahead FIFO for the CPU.
module kbd_ctrl #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         kb_data,
  input  logic                     kb_ready,
  output logic                     kb_rdn,
  input  logic                     cpu_rd,
  output logic [WIDTH-1:0]         cpu_rdata,
  output logic                     cpu_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   kb_rdn_q, kb_rdn_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;

  logic push, pop, full, empty, push_ok, drop;

  // Drain FSM: kb_rdn is registered, so it goes low in the same edge that enters ACK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      kb_rdn_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      kb_rdn_q <= kb_rdn_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    kb_rdn_d = 1'b1;
    case (state_q)
      IDLE: if (kb_ready) state_d = ACK;
      ACK:  state_d = HOLD;
      HOLD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == ACK) kb_rdn_d = 1'b0;
  end

  // FIFO bookkeeping; a full FIFO still accepts a push when a pop frees the head.
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign push    = (state_q == ACK);
  assign pop     = cpu_rd && !empty;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push_ok) count_d = count_q - CW'(1);
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is invisible while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= kb_data;
  end

  assign kb_rdn     = kb_rdn_q;
  assign cpu_valid  = !empty;
  assign cpu_rdata  = empty ? '0 : mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_kbd_ctrl.sv
// Directed bench for kbd_ctrl with a queue-based PS/2 receiver model.
module tb_kbd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] kb_data;
  logic       kb_ready;
  logic       kb_rdn;
  logic       cpu_rd;
  logic [7:0] cpu_rdata;
  logic       cpu_valid;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       ovf_clr;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_mem [256];
  int rx_wr = 0;
  int rx_rd = 0;
  int rdn_pulses = 0;

  kbd_ctrl #(.DEPTH(8), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .kb_data(kb_data), .kb_ready(kb_ready), .kb_rdn(kb_rdn),
    .cpu_rd(cpu_rd), .cpu_rdata(cpu_rdata), .cpu_valid(cpu_valid),
    .fifo_count(fifo_count), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Receiver model: advances its read pointer on every low kb_rdn edge.
  assign kb_ready = (rx_rd != rx_wr);
  assign kb_data  = rx_mem[rx_rd[7:0]];

  always @(posedge clk) begin
    if (kb_rdn === 1'b0) begin
      rdn_pulses <= rdn_pulses + 1;
      if (rx_rd != rx_wr) rx_rd <= rx_rd + 1;
    end
  end

  task automatic push_code(input logic [7:0] c);
    rx_mem[rx_wr[7:0]] = c;
    rx_wr = rx_wr + 1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (kb_rdn === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic pop_one();
    cpu_rd = 1'b1;
    cycles(1);
    cpu_rd = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (kb_rdn !== 1'b1) begin errors++; $display("FAIL reset_kb_rdn got %b want 1", kb_rdn); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    checks++; if (cpu_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", cpu_valid); end
    checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", cpu_rdata); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    int p0;
    p0 = rdn_pulses;
    push_code(8'h1C);
    cycles(1);
    checks++; if (kb_rdn !== 1'b0) begin errors++; $display("FAIL single_rdn_low got %b want 0", kb_rdn); end
    cycles(1);
    checks++; if (kb_rdn !== 1'b1) begin errors++; $display("FAIL single_rdn_high got %b want 1", kb_rdn); end
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL single_count got %0d want 1", fifo_count); end
    checks++; if (cpu_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", cpu_valid); end
    checks++; if (cpu_rdata !== 8'h1C) begin errors++; $display("FAIL single_rdata got %h want 1c", cpu_rdata); end
    cycles(4);
    checks++; if (rdn_pulses - p0 !== 1) begin errors++; $display("FAIL single_pulses got %0d want 1", rdn_pulses - p0); end
    pop_one();
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL single_pop_count got %0d want 0", fifo_count); end
    checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL single_pop_rdata got %h want 00", cpu_rdata); end
    $display("test_single done");
  endtask

  task automatic test_burst();
    int p0;
    p0 = rdn_pulses;
    for (int i = 1; i <= 10; i++) push_code(8'(i));
    cycles(28);
    checks++; if (rdn_pulses - p0 !== 9) begin errors++; $display("FAIL burst_rate9 got %0d want 9", rdn_pulses - p0); end
    cycles(1);
    checks++; if (rdn_pulses - p0 !== 10) begin errors++; $display("FAIL burst_rate10 got %0d want 10", rdn_pulses - p0); end
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL burst_count got %0d want 8", fifo_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL burst_ovf got %b want 1", overflow); end
    cycles(5);
    checks++; if (rdn_pulses - p0 !== 10) begin errors++; $display("FAIL burst_pulses got %0d want 10", rdn_pulses - p0); end
    for (int i = 1; i <= 8; i++) begin
      checks++; if (cpu_rdata !== 8'(i)) begin errors++; $display("FAIL burst_pop%0d got %h want %h", i, cpu_rdata, 8'(i)); end
      pop_one();
    end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL burst_empty got %0d want 0", fifo_count); end
    ovf_clr = 1'b1;
    cycles(1);
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL burst_ovf_clr got %b want 0", overflow); end
    $display("test_burst done");
  endtask

  task automatic test_wrap();
    bit ok;
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) push_code(8'h50 + 8'(i));
    cycles(16);
    for (int i = 0; i < 5; i++) begin
      checks++; if (cpu_rdata !== 8'h50 + 8'(i)) begin errors++; $display("FAIL wrap_pre%0d got %h want %h", i, cpu_rdata, 8'h50 + 8'(i)); end
      pop_one();
    end
    for (int i = 0; i < 8; i++) push_code(8'hA0 + 8'(i));
    cycles(26);
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL wrap_full got %0d want 8", fifo_count); end
    push_code(8'hA8);
    wait_ack(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_ack_timeout got 0 want 1"); end
    pop_one();
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL wrap_simul_count got %0d want 8", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_simul_ovf got %b want 0", overflow); end
    for (int i = 1; i <= 8; i++) begin
      checks++; if (cpu_rdata !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL wrap_pop%0d got %h want %h", i, cpu_rdata, 8'hA0 + 8'(i)); end
      pop_one();
    end
    checks++; if (cpu_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty got %b want 0", cpu_valid); end
    $display("test_wrap done");
  endtask

  task automatic test_empty_setwins();
    bit ok;
    pop_one();
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL epop_count got %0d want 0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL epop_ovf got %b want 0", overflow); end
    checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL epop_rdata got %h want 00", cpu_rdata); end
    for (int i = 0; i < 8; i++) push_code(8'hB0 + 8'(i));
    cycles(26);
    push_code(8'hB8);
    wait_ack(ok);
    checks++; if (!ok) begin errors++; $display("FAIL setwins_ack_timeout got 0 want 1"); end
    ovf_clr = 1'b1;
    cycles(1);
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL setwins_ovf got %b want 1", overflow); end
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL setwins_count got %0d want 8", fifo_count); end
    checks++; if (cpu_rdata !== 8'hB0) begin errors++; $display("FAIL setwins_head got %h want b0", cpu_rdata); end
    $display("test_empty_setwins done");
  endtask

  task automatic test_reset_mid_ack();
    bit ok;
    pop_one();
    cycles(2);
    push_code(8'hC5);
    wait_ack(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rack_ack_timeout got 0 want 1"); end
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    checks++; if (kb_rdn !== 1'b1) begin errors++; $display("FAIL rack_rdn got %b want 1", kb_rdn); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL rack_count got %0d want 0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rack_ovf got %b want 0", overflow); end
    cycles(6);
    checks++; if (cpu_valid !== 1'b0) begin errors++; $display("FAIL rack_nostore got %b want 0", cpu_valid); end
    push_code(8'hD7);
    cycles(4);
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL rack_after_count got %0d want 1", fifo_count); end
    checks++; if (cpu_rdata !== 8'hD7) begin errors++; $display("FAIL rack_after_rdata got %h want d7", cpu_rdata); end
    $display("test_reset_mid_ack done");
  endtask

  initial begin
    rst = 1'b1;
    cpu_rd = 1'b0;
    ovf_clr = 1'b0;
    cycles(3);
    test_reset();
    rst = 1'b0;
    cycles(1);
    test_single();
    test_burst();
    test_wrap();
    test_empty_setwins();
    test_reset_mid_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/kbd_ctrl.md
KBD_CTRL -- requirements
Module: kbd_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning scan-code width in bits.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port kb_data  input  WIDTH  scan code presented by the PS/2 receiver, valid while kb_ready=1.
REQ-006 The block SHALL have port kb_ready  input  1  PS/2 receiver holds at least one unread code.
REQ-007 The block SHALL have port kb_rdn  output  1  active-low read strobe to the PS/2 receiver; low for one cycle advances its read pointer.
REQ-008 The block SHALL have port cpu_rd  input  1  CPU pop request, one cycle per byte.
REQ-009 The block SHALL have port cpu_rdata  output  WIDTH  FIFO head (show-ahead).
REQ-010 The block SHALL have port cpu_valid  output  1  FIFO non-empty.
REQ-011 The block SHALL have port fifo_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 The block SHALL have port overflow  output  1  sticky flag: a code was dropped because the FIFO was full.
REQ-013 The block SHALL have port ovf_clr  input  1  clears overflow.

Function
REQ-014 Drain FSM states SHALL be IDLE, ACK and HOLD, one cycle each in ACK and HOLD.
REQ-015 IDLE SHALL go to ACK on kb_ready=1 and otherwise stay in IDLE.
REQ-016 In ACK the block SHALL drive kb_rdn=0, sample kb_data and push it into the FIFO at the end of the cycle.
REQ-017 ACK SHALL always go to HOLD.
REQ-018 In HOLD the block SHALL drive kb_rdn=1, ignore kb_ready (lets the receiver update its pointer), and go to IDLE.
REQ-019 kb_rdn SHALL be registered and equal 1 in every state other than ACK.
REQ-020 Sustained drain rate SHALL be one code per 3 cycles; kb_ready to kb_rdn=0 latency SHALL be 1 cycle.
REQ-021 FIFO SHALL be circular with WIDTH x DEPTH storage, write and read pointers of $clog2(DEPTH) bits wrapping DEPTH-1 to 0, and a separate occupancy counter.
REQ-022 cpu_valid SHALL be (fifo_count != 0).
REQ-023 cpu_rdata SHALL equal the head entry when cpu_valid=1 and all-zero when empty.
REQ-024 cpu_rd with cpu_valid=1 SHALL advance the read pointer; the next head SHALL appear on cpu_rdata the following cycle.
REQ-025 cpu_rd with cpu_valid=0 SHALL be ignored: no pointer or count change, no error flag.
REQ-026 A push and a pop in the same cycle SHALL both take effect with fifo_count unchanged, including when the FIFO is full.
REQ-027 A push with FIFO full and no same-cycle pop SHALL discard the code, leave the FIFO unchanged, and set overflow=1 next cycle.
REQ-028 In the full-drop case kb_rdn SHALL still pulse, so the receiver never stalls.
REQ-029 overflow SHALL stay set until ovf_clr=1; when ovf_clr and a new drop occur in the same cycle, set wins.
REQ-030 The FIFO SHALL store codes byte-exact in arrival order; break prefixes (F0/E0) SHALL be stored as ordinary bytes, with no decoding.

Reset
REQ-031 With rst=1 at a clock edge, state SHALL become IDLE, kb_rdn=1, both pointers 0, fifo_count=0, overflow=0, cpu_valid=0 and cpu_rdata=0.
REQ-032 Reset SHALL override every same-cycle push, pop and ovf_clr.
REQ-033 Reset asserted while in ACK SHALL discard the sampled code and return kb_rdn to 1 at that edge.
REQ-034 FIFO storage contents SHALL need no reset, since they are unobservable while empty.

Verification
REQ-035 Single code: kb_ready=1 with kb_data=8'h1C for one code, then 0 -> kb_rdn=0 exactly one cycle, 1 cycle after kb_ready rises; then cpu_valid=1, cpu_rdata=8'h1C, fifo_count=1; cpu_rd pulse -> fifo_count=0, cpu_rdata=8'h00.
REQ-036 Burst/full: 10 codes 8'h01..8'h0A, no cpu_rd -> fifo_count=8, overflow=1, 10 kb_rdn pulses; 8 pops return 8'h01..8'h08; ovf_clr -> overflow=0.
REQ-037 Wrap and simultaneity: FIFO holding 8 entries, read pointer at 5, cpu_rd in the same cycle as an ACK push -> fifo_count stays 8, overflow stays 0, and pop order continues correctly across pointer wrap.
REQ-038 Empty pop and set-wins: cpu_rd with FIFO empty -> no change; ovf_clr asserted on the same cycle as a full-drop -> overflow=1.
REQ-039 Reset mid-ACK: rst=1 on the ACK cycle -> kb_rdn=1 after that edge, fifo_count=0, and no code stored.
